// File: rtl/game_engine_pkg.sv
// runner_pkg: shared FSM state encoding and lane/score widths for the runner game
package runner_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2} state_t;
  localparam int LANE_W = 6;
  localparam int SCORE_W = 8;
endpackage

// File: rtl/game_engine_if.sv
// game_engine_if: player I/O bundle -- startBtn/jumpBtn in; ceilingBits, floorBits, playerPos, score, showScore out
interface game_engine_if;
  import runner_pkg::*;
  logic startBtn;
  logic jumpBtn;
  logic [LANE_W-1:0] ceilingBits;
  logic [LANE_W-1:0] floorBits;
  logic playerPos;
  logic [SCORE_W-1:0] score;
  logic showScore;
  modport master(output startBtn, jumpBtn, input ceilingBits, floorBits, playerPos, score, showScore);
  modport slave(input startBtn, jumpBtn, output ceilingBits, floorBits, playerPos, score, showScore);
endinterface

// File: rtl/game_engine_obstacle_gen.sv
// obstacle_gen: 8-bit Fibonacci LFSR (taps 8,6,5,4) stepped on tick -- in clk, rst, tick, ceil0, floor0; out newCeil, newFloor
module obstacle_gen #(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic ceil0,
  input  logic floor0,
  output logic newCeil,
  output logic newFloor
);
  logic [7:0] lfsr_q, lfsr_d;
  always_comb begin
    lfsr_d = tick ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]} : lfsr_q;
    newFloor = lfsr_q[1:0] == 2'b01 && !ceil0;
    newCeil = lfsr_q[1:0] == 2'b10 && !floor0;
  end
  always_ff @(posedge clk) lfsr_q <= rst ? LFSR_SEED : lfsr_d;
endmodule

// File: rtl/game_engine.sv
// game_engine: two-lane runner game FSM -- clk, rst, io (game_engine_if.slave: buttons in, lanes/player/score/showScore out)
module game_engine
  import runner_pkg::*;
#(
  parameter int TICK_DIV = 25000000,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input logic clk,
  input logic rst,
  game_engine_if.slave io
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LANE_W-1:0] ceil_q, ceil_d, floor_q, floor_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic pos_q, pos_d, show_q, show_d;
  logic start_q, jump_q;
  logic start_edge, jump_edge, hit, tick, adv, new_ceil, new_floor;
  assign start_edge = io.startBtn && !start_q;
  assign jump_edge = io.jumpBtn && !jump_q;
  assign hit = state_q == RUN && (pos_q ? ceil_q[LANE_W-1] : floor_q[LANE_W-1]);
  assign tick = state_q == RUN && cnt_q == LAST;
  // a collision freezes the field, so the generator must not step either
  assign adv = tick && !hit;
  obstacle_gen #(.LFSR_SEED(LFSR_SEED)) u_gen (
    .clk(clk), .rst(rst), .tick(adv), .ceil0(ceil_q[0]), .floor0(floor_q[0]),
    .newCeil(new_ceil), .newFloor(new_floor)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    ceil_d = ceil_q;
    floor_d = floor_q;
    score_d = score_q;
    pos_d = pos_q;
    if (state_q == IDLE && start_edge) begin
      state_d = RUN;
      ceil_d = '0;
      floor_d = '0;
      score_d = '0;
    end else if (state_q == OVER && start_edge) begin
      state_d = IDLE;
      ceil_d = '0;
      floor_d = '0;
      score_d = '0;
    end else if (hit) begin
      state_d = OVER;
    end else if (state_q == RUN) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      ceil_d = tick ? {ceil_q[LANE_W-2:0], new_ceil} : ceil_q;
      floor_d = tick ? {floor_q[LANE_W-2:0], new_floor} : floor_q;
      score_d = score_q + SCORE_W'(tick && (ceil_q[LANE_W-1] || floor_q[LANE_W-1]) && score_q != '1);
      pos_d = pos_q ^ jump_edge;
    end
    show_d = state_d == OVER;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ceil_q <= '0;
      floor_q <= '0;
      score_q <= '0;
      pos_q <= 1'b0;
      show_q <= 1'b0;
      start_q <= 1'b0;
      jump_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ceil_q <= ceil_d;
      floor_q <= floor_d;
      score_q <= score_d;
      pos_q <= pos_d;
      show_q <= show_d;
      start_q <= io.startBtn;
      jump_q <= io.jumpBtn;
    end
  end
  assign io.ceilingBits = ceil_q;
  assign io.floorBits = floor_q;
  assign io.playerPos = pos_q;
  assign io.score = score_q;
  assign io.showScore = show_q;
endmodule
